// File: rtl/mano_pkg.sv
// +----------------------------------------------------------------------+
// | mano_pkg : shared codes for the basic-computer control unit          |
// | Bus selects, AC/E operations, opcodes and register-reference bits.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package mano_pkg;

    typedef enum logic [2:0] {
        BUS_NONE = 3'd0,
        BUS_AR   = 3'd1,
        BUS_PC   = 3'd2,
        BUS_DR   = 3'd3,
        BUS_AC   = 3'd4,
        BUS_IR   = 3'd5,
        BUS_MEM  = 3'd7
    } bus_sel_e;

    typedef enum logic [3:0] {
        AC_NONE = 4'd0,
        AC_AND  = 4'd1,
        AC_ADD  = 4'd2,
        AC_LDDR = 4'd3,
        AC_CLR  = 4'd4,
        AC_CMA  = 4'd5,
        AC_CIR  = 4'd6,
        AC_CIL  = 4'd7,
        AC_INC  = 4'd8,
        AC_INPR = 4'd9
    } ac_op_e;

    typedef enum logic [1:0] {
        E_NONE = 2'd0,
        E_CLR  = 2'd1,
        E_CMA  = 2'd2
    } e_op_e;

    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_ADD    = 3'd1;
    localparam logic [2:0] OP_LDA    = 3'd2;
    localparam logic [2:0] OP_STA    = 3'd3;
    localparam logic [2:0] OP_BUN    = 3'd4;
    localparam logic [2:0] OP_BSA    = 3'd5;
    localparam logic [2:0] OP_ISZ    = 3'd6;
    localparam logic [2:0] OP_REG_IO = 3'd7;

    localparam int B_CLA = 11;
    localparam int B_CLE = 10;
    localparam int B_CMA = 9;
    localparam int B_CME = 8;
    localparam int B_CIR = 7;
    localparam int B_CIL = 6;
    localparam int B_INC = 5;
    localparam int B_SPA = 4;
    localparam int B_SNA = 3;
    localparam int B_SZA = 2;
    localparam int B_SZE = 1;
    localparam int B_HLT = 0;
    localparam int B_INP = 11;
    localparam int B_OUT = 10;
    localparam int B_SKI = 9;
    localparam int B_SKO = 8;

    // Only one AC operation can be issued per cycle; earlier bits dominate.
    function automatic ac_op_e reg_ac_op(input logic [11:0] f);
        if (f[B_CLA])      return AC_CLR;
        else if (f[B_CMA]) return AC_CMA;
        else if (f[B_CIR]) return AC_CIR;
        else if (f[B_CIL]) return AC_CIL;
        else if (f[B_INC]) return AC_INC;
        return AC_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mano_ctrl_unit_if.sv
// +----------------------------------------------------------------------+
// | mano_ctrl_unit_if : control unit <-> datapath signal bundle          |
// | FGI/FGO exist only when MANO_IO_EN is defined.                       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface mano_ctrl_unit_if #(
    parameter int SC_W = 3
);
    logic            START;
    logic [15:0]     IN_IR;
    logic            AC_MSB;
    logic            AC_ZERO;
    logic            E_IN;
    logic            DR_ZERO;
`ifdef MANO_IO_EN
    logic            FGI;
    logic            FGO;
`endif
    logic [SC_W-1:0] t;
    logic            RUN;
    logic            I_FF;
    logic [2:0]      BUS_SEL;
    logic            MEM_RD;
    logic            MEM_WR;
    logic            LD_AR;
    logic            INC_AR;
    logic            LD_PC;
    logic            INC_PC;
    logic            LD_DR;
    logic            INC_DR;
    logic            LD_IR;
    logic [3:0]      AC_OP;
    logic [1:0]      E_OP;
    logic            OUT_LD;

`ifdef MANO_IO_EN
    modport master (
        input  START, IN_IR, AC_MSB, AC_ZERO, E_IN, DR_ZERO, FGI, FGO,
        output t, RUN, I_FF, BUS_SEL, MEM_RD, MEM_WR, LD_AR, INC_AR, LD_PC,
               INC_PC, LD_DR, INC_DR, LD_IR, AC_OP, E_OP, OUT_LD
    );
    modport slave (
        output START, IN_IR, AC_MSB, AC_ZERO, E_IN, DR_ZERO, FGI, FGO,
        input  t, RUN, I_FF, BUS_SEL, MEM_RD, MEM_WR, LD_AR, INC_AR, LD_PC,
               INC_PC, LD_DR, INC_DR, LD_IR, AC_OP, E_OP, OUT_LD
    );
`else
    modport master (
        input  START, IN_IR, AC_MSB, AC_ZERO, E_IN, DR_ZERO,
        output t, RUN, I_FF, BUS_SEL, MEM_RD, MEM_WR, LD_AR, INC_AR, LD_PC,
               INC_PC, LD_DR, INC_DR, LD_IR, AC_OP, E_OP, OUT_LD
    );
    modport slave (
        output START, IN_IR, AC_MSB, AC_ZERO, E_IN, DR_ZERO,
        input  t, RUN, I_FF, BUS_SEL, MEM_RD, MEM_WR, LD_AR, INC_AR, LD_PC,
               INC_PC, LD_DR, INC_DR, LD_IR, AC_OP, E_OP, OUT_LD
    );
`endif

endinterface

`default_nettype wire

// File: rtl/mano_seq_counter.sv
// +----------------------------------------------------------------------+
// | mano_seq_counter : sequence counter with one-hot timing decode       |
// | Counts while run=1, clears on clr or when halted; wraps 7 -> 0.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mano_seq_counter #(
    parameter int SC_W = 3
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   run,
    input  wire logic                   clr,
    output logic [SC_W-1:0]             sc,
    output logic [(1<<SC_W)-1:0]        tdec
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc <= '0;
        end else if (!run || clr) begin
            sc <= '0;
        end else begin
            sc <= sc + 1'b1;
        end
    end

    assign tdec = {{((1<<SC_W)-1){1'b0}}, 1'b1} << sc;

endmodule

`default_nettype wire

// File: rtl/mano_ctrl_unit.sv
// +----------------------------------------------------------------------+
// | mano_ctrl_unit : basic-computer control unit (SC, S and I flops)     |
// | Optional I/O instruction decode enabled by MANO_IO_EN.               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mano_ctrl_unit
    import mano_pkg::*;
#(
    parameter int SC_W = 3,
    parameter int AW   = 12
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    mano_ctrl_unit_if.master   ctl
);

    logic                   s_ff;
    logic                   i_ff;
    logic                   clr_sc;
    logic                   halt;
    logic [SC_W-1:0]        sc;
    logic [(1<<SC_W)-1:0]   tdec;
    logic [2:0]             opcode;
    logic [AW-1:0]          fld;

    assign opcode = ctl.IN_IR[14:12];
    assign fld    = ctl.IN_IR[AW-1:0];

    mano_seq_counter #(.SC_W(SC_W)) u_sc (
        .clk  (CLK),
        .rst  (RST),
        .run  (s_ff),
        .clr  (clr_sc),
        .sc   (sc),
        .tdec (tdec)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s_ff <= 1'b0;
            i_ff <= 1'b0;
        end else begin
            if (halt) begin
                s_ff <= 1'b0;
            end else if (ctl.START) begin
                s_ff <= 1'b1;
            end
            if (s_ff && tdec[2]) begin
                i_ff <= ctl.IN_IR[15];
            end
        end
    end

    always_comb begin
        ctl.BUS_SEL = BUS_NONE;
        ctl.MEM_RD  = 1'b0;
        ctl.MEM_WR  = 1'b0;
        ctl.LD_AR   = 1'b0;
        ctl.INC_AR  = 1'b0;
        ctl.LD_PC   = 1'b0;
        ctl.INC_PC  = 1'b0;
        ctl.LD_DR   = 1'b0;
        ctl.INC_DR  = 1'b0;
        ctl.LD_IR   = 1'b0;
        ctl.AC_OP   = AC_NONE;
        ctl.E_OP    = E_NONE;
        ctl.OUT_LD  = 1'b0;
        clr_sc      = 1'b0;
        halt        = 1'b0;
        if (s_ff) begin
            if (tdec[0]) begin
                ctl.BUS_SEL = BUS_PC;
                ctl.LD_AR   = 1'b1;
            end else if (tdec[1]) begin
                ctl.BUS_SEL = BUS_MEM;
                ctl.MEM_RD  = 1'b1;
                ctl.LD_IR   = 1'b1;
                ctl.INC_PC  = 1'b1;
            end else if (tdec[2]) begin
                ctl.BUS_SEL = BUS_IR;
                ctl.LD_AR   = 1'b1;
            end else if (tdec[3]) begin
                if (opcode != OP_REG_IO) begin
                    if (i_ff) begin
                        ctl.BUS_SEL = BUS_MEM;
                        ctl.MEM_RD  = 1'b1;
                        ctl.LD_AR   = 1'b1;
                    end
                end else begin
                    clr_sc = 1'b1;
                    if (!i_ff) begin
                        ctl.AC_OP  = reg_ac_op(fld);
                        ctl.E_OP   = fld[B_CLE] ? E_CLR : (fld[B_CME] ? E_CMA : E_NONE);
                        ctl.INC_PC = (fld[B_SPA] && !ctl.AC_MSB) || (fld[B_SNA] && ctl.AC_MSB)
                                  || (fld[B_SZA] && ctl.AC_ZERO) || (fld[B_SZE] && !ctl.E_IN);
                        halt       = fld[B_HLT];
                    end
`ifdef MANO_IO_EN
                    else begin
                        if (fld[B_INP]) ctl.AC_OP = AC_INPR;
                        ctl.OUT_LD = fld[B_OUT];
                        ctl.INC_PC = (fld[B_SKI] && ctl.FGI) || (fld[B_SKO] && ctl.FGO);
                    end
`endif
                end
            end else if (opcode != OP_REG_IO) begin
                // T4..T6 of memory-reference instructions; T7 falls through with no strobes
                case (opcode)
                    OP_AND, OP_ADD, OP_LDA: begin
                        if (tdec[4]) begin
                            ctl.BUS_SEL = BUS_MEM;
                            ctl.MEM_RD  = 1'b1;
                            ctl.LD_DR   = 1'b1;
                        end else if (tdec[5]) begin
                            ctl.AC_OP = (opcode == OP_AND) ? AC_AND :
                                        (opcode == OP_ADD) ? AC_ADD : AC_LDDR;
                            clr_sc    = 1'b1;
                        end
                    end
                    OP_STA: begin
                        if (tdec[4]) begin
                            ctl.BUS_SEL = BUS_AC;
                            ctl.MEM_WR  = 1'b1;
                            clr_sc      = 1'b1;
                        end
                    end
                    OP_BUN: begin
                        if (tdec[4]) begin
                            ctl.BUS_SEL = BUS_AR;
                            ctl.LD_PC   = 1'b1;
                            clr_sc      = 1'b1;
                        end
                    end
                    OP_BSA: begin
                        if (tdec[4]) begin
                            ctl.BUS_SEL = BUS_PC;
                            ctl.MEM_WR  = 1'b1;
                            ctl.INC_AR  = 1'b1;
                        end else if (tdec[5]) begin
                            ctl.BUS_SEL = BUS_AR;
                            ctl.LD_PC   = 1'b1;
                            clr_sc      = 1'b1;
                        end
                    end
                    OP_ISZ: begin
                        if (tdec[4]) begin
                            ctl.BUS_SEL = BUS_MEM;
                            ctl.MEM_RD  = 1'b1;
                            ctl.LD_DR   = 1'b1;
                        end else if (tdec[5]) begin
                            ctl.INC_DR  = 1'b1;
                        end else if (tdec[6]) begin
                            ctl.BUS_SEL = BUS_DR;
                            ctl.MEM_WR  = 1'b1;
                            ctl.INC_PC  = ctl.DR_ZERO;
                            clr_sc      = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ctl.t    = sc;
    assign ctl.RUN  = s_ff;
    assign ctl.I_FF = i_ff;

endmodule

`default_nettype wire
